// File: rtl/rv0_id_ex_stage_if.sv
// ID->EX stage bus: ID-side push handshake, WB forwarding feed, EX-side head output.
// Latency: none (wires only).
// Backpressure: id_ready_o / ex_ready_i carry the valid/ready handshakes.
// Ports (modport slave = the stage, master = its environment):
//   flush_i, id_valid_i/id_ready_o, id_insn_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
//   wb_we_i, wb_rd_i, wb_wdata_i, ex_valid_o/ex_ready_i, ex_insn_o, ex_pc_o,
//   ex_rdata1_o, ex_rdata2_o, ex_rs2_data_o
interface rv0_id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            id_valid_i;
  logic            id_ready_o;
  logic [31:0]     id_insn_i;
  logic [XLEN-1:0] id_pc_i;
  logic [XLEN-1:0] id_rs1_data_i;
  logic [XLEN-1:0] id_rs2_data_i;
  logic            wb_we_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_wdata_i;
  logic            ex_valid_o;
  logic            ex_ready_i;
  logic [31:0]     ex_insn_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] ex_rdata1_o;
  logic [XLEN-1:0] ex_rdata2_o;
  logic [XLEN-1:0] ex_rs2_data_o;

  modport slave (
    input  flush_i, id_valid_i, id_insn_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
           wb_we_i, wb_rd_i, wb_wdata_i, ex_ready_i,
    output id_ready_o, ex_valid_o, ex_insn_o, ex_pc_o, ex_rdata1_o, ex_rdata2_o,
           ex_rs2_data_o
  );

  modport master (
    output flush_i, id_valid_i, id_insn_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
           wb_we_i, wb_rd_i, wb_wdata_i, ex_ready_i,
    input  id_ready_o, ex_valid_o, ex_insn_o, ex_pc_o, ex_rdata1_o, ex_rdata2_o,
           ex_rs2_data_o
  );
endinterface

// File: rtl/rv0_id_ex_stage.sv
// ID->EX boundary: 2-entry skid buffer with WB forwarding, ALU operand select on the head.
// Latency: 1 cycle from acceptance to ex_* (empty buffer); ex_* combinational from the head.
// Backpressure: id_ready_o low when 2 held (from registered count only); ex_ready_i pops head.
// Ports: clk_i, rst_i (sync, active-high), bus (rv0_id_ex_stage_if.slave, see interface file).
module rv0_id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rv0_id_ex_stage_if.slave   bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
  } ent_t;

  ent_t       ent_q [2];
  ent_t       ent_d [2];
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;

  logic       id_ready;
  logic       ex_valid;
  logic       push;
  logic       pop;

  // x0 is hardwired zero, so a WB to rd=0 must never be forwarded.
  function automatic logic wb_hit(input logic we, input logic [4:0] rd, input logic [4:0] f);
    return we && (rd != 5'd0) && (rd == f);
  endfunction

  assign id_ready = (cnt_q != 2'd2) & ~rst_i;
  assign ex_valid = (cnt_q != 2'd0);
  assign push     = bus.id_valid_i & id_ready;
  assign pop      = ex_valid & bus.ex_ready_i;

  assign bus.id_ready_o = id_ready;
  assign bus.ex_valid_o = ex_valid;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;

    // Keep stalled operands current; the entry leaving this cycle needs no update.
    for (int i = 0; i < 2; i++) begin
      if (((cnt_q == 2'd2) || ((cnt_q == 2'd1) && (head_q == 1'(i)))) &&
          !(pop && (head_q == 1'(i)))) begin
        if (wb_hit(bus.wb_we_i, bus.wb_rd_i, ent_q[i].insn[19:15]))
          ent_d[i].rs1v = bus.wb_wdata_i;
        if (wb_hit(bus.wb_we_i, bus.wb_rd_i, ent_q[i].insn[24:20]))
          ent_d[i].rs2v = bus.wb_wdata_i;
      end
    end

    // The tail slot is never a live entry when push is allowed, so no overlap with above.
    if (push) begin
      ent_d[tail_q].insn = bus.id_insn_i;
      ent_d[tail_q].pc   = bus.id_pc_i;
      ent_d[tail_q].rs1v = wb_hit(bus.wb_we_i, bus.wb_rd_i, bus.id_insn_i[19:15]) ?
                           bus.wb_wdata_i : bus.id_rs1_data_i;
      ent_d[tail_q].rs2v = wb_hit(bus.wb_we_i, bus.wb_rd_i, bus.id_insn_i[24:20]) ?
                           bus.wb_wdata_i : bus.id_rs2_data_i;
      tail_d = ~tail_q;
    end

    if (pop) head_d = ~head_q;

    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    if (rst_i || bus.flush_i) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      cnt_d  = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < 2; i++) ent_q[i] <= ent_d[i];
    end
  end

  // Head presentation with same-cycle WB bypass and ALU operand select.
  ent_t            hd;
  logic [XLEN-1:0] rs1f, rs2f;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  always_comb begin
    hd    = ent_q[head_q];
    rs1f  = wb_hit(bus.wb_we_i, bus.wb_rd_i, hd.insn[19:15]) ? bus.wb_wdata_i : hd.rs1v;
    rs2f  = wb_hit(bus.wb_we_i, bus.wb_rd_i, hd.insn[24:20]) ? bus.wb_wdata_i : hd.rs2v;
    imm_i = {{(XLEN-12){hd.insn[31]}}, hd.insn[31:20]};
    imm_s = {{(XLEN-12){hd.insn[31]}}, hd.insn[31:25], hd.insn[11:7]};
    imm_u = {{(XLEN-32){hd.insn[31]}}, hd.insn[31:12], 12'b0};

    bus.ex_insn_o     = '0;
    bus.ex_pc_o       = '0;
    bus.ex_rdata1_o   = '0;
    bus.ex_rdata2_o   = '0;
    bus.ex_rs2_data_o = '0;

    if (ex_valid) begin
      bus.ex_insn_o     = hd.insn;
      bus.ex_pc_o       = hd.pc;
      bus.ex_rs2_data_o = rs2f;
      unique case (hd.insn[6:0])
        OPC_OP_IMM, OPC_LOAD: begin
          bus.ex_rdata1_o = rs1f;
          bus.ex_rdata2_o = imm_i;
        end
        OPC_STORE: begin
          bus.ex_rdata1_o = rs1f;
          bus.ex_rdata2_o = imm_s;
        end
        OPC_LUI: begin
          bus.ex_rdata1_o = '0;
          bus.ex_rdata2_o = imm_u;
        end
        OPC_AUIPC: begin
          bus.ex_rdata1_o = hd.pc;
          bus.ex_rdata2_o = imm_u;
        end
        // Link address pc+4 computed by the ALU's default add.
        OPC_JAL, OPC_JALR: begin
          bus.ex_rdata1_o = hd.pc;
          bus.ex_rdata2_o = XLEN'(4);
        end
        default: begin
          bus.ex_rdata1_o = rs1f;
          bus.ex_rdata2_o = rs2f;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv0_id_ex_stage.sv
module tb_rv0_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv0_id_ex_stage_if #(.XLEN(32)) bus ();

  rv0_id_ex_stage #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of held instructions ----------------
  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
  } m_ent_t;

  m_ent_t q[$];

  function automatic logic [31:0] fwd(input logic [31:0] v, input logic [4:0] reg_idx,
                                      input logic we, input logic [4:0] rd,
                                      input logic [31:0] wd);
    if (we && rd != 0 && rd == reg_idx) return wd;
    return v;
  endfunction

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  always @(posedge clk) begin
    if (rst || bus.flush_i) begin
      q.delete();
    end else begin
      bit do_push, do_pop;
      m_ent_t e;
      do_pop  = (q.size() > 0) && bus.ex_ready_i;
      do_push = bus.id_valid_i && (q.size() < 2);
      for (int i = 0; i < q.size(); i++) begin
        q[i].rs1v = fwd(q[i].rs1v, q[i].insn[19:15], bus.wb_we_i, bus.wb_rd_i, bus.wb_wdata_i);
        q[i].rs2v = fwd(q[i].rs2v, q[i].insn[24:20], bus.wb_we_i, bus.wb_rd_i, bus.wb_wdata_i);
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.insn = bus.id_insn_i;
        e.pc   = bus.id_pc_i;
        e.rs1v = fwd(bus.id_rs1_data_i, bus.id_insn_i[19:15], bus.wb_we_i, bus.wb_rd_i, bus.wb_wdata_i);
        e.rs2v = fwd(bus.id_rs2_data_i, bus.id_insn_i[24:20], bus.wb_we_i, bus.wb_rd_i, bus.wb_wdata_i);
        q.push_back(e);
      end
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] r1, r2, s2, u;
    chk("id_ready", {31'b0, bus.id_ready_o}, {31'b0, (q.size() < 2) && !rst});
    chk("ex_valid", {31'b0, bus.ex_valid_o}, {31'b0, q.size() != 0});
    if (q.size() == 0) begin
      chk("idle_insn",   bus.ex_insn_o, 32'h0);
      chk("idle_pc",     bus.ex_pc_o, 32'h0);
      chk("idle_rdata1", bus.ex_rdata1_o, 32'h0);
      chk("idle_rdata2", bus.ex_rdata2_o, 32'h0);
      chk("idle_rs2",    bus.ex_rs2_data_o, 32'h0);
    end else begin
      r1 = fwd(q[0].rs1v, q[0].insn[19:15], bus.wb_we_i, bus.wb_rd_i, bus.wb_wdata_i);
      s2 = fwd(q[0].rs2v, q[0].insn[24:20], bus.wb_we_i, bus.wb_rd_i, bus.wb_wdata_i);
      r2 = s2;
      u  = {q[0].insn[31:12], 12'h000};
      case (q[0].insn[6:0])
        7'h13, 7'h03: r2 = sx12(q[0].insn[31:20]);
        7'h23:        r2 = sx12({q[0].insn[31:25], q[0].insn[11:7]});
        7'h37: begin r1 = 0; r2 = u; end
        7'h17: begin r1 = q[0].pc; r2 = u; end
        7'h6F, 7'h67: begin r1 = q[0].pc; r2 = 4; end
        default: ;
      endcase
      chk("ex_insn",   bus.ex_insn_o, q[0].insn);
      chk("ex_pc",     bus.ex_pc_o, q[0].pc);
      chk("ex_rdata1", bus.ex_rdata1_o, r1);
      chk("ex_rdata2", bus.ex_rdata2_o, r2);
      chk("ex_rs2",    bus.ex_rs2_data_o, s2);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [31:0] insn, input logic [31:0] pc,
                          input logic [31:0] d1, input logic [31:0] d2);
    bus.id_valid_i    = 1'b1;
    bus.id_insn_i     = insn;
    bus.id_pc_i       = pc;
    bus.id_rs1_data_i = d1;
    bus.id_rs2_data_i = d2;
  endtask

  task automatic wb_set(input logic we, input logic [4:0] rd, input logic [31:0] wd);
    bus.wb_we_i    = we;
    bus.wb_rd_i    = rd;
    bus.wb_wdata_i = wd;
  endtask

  logic [31:0] t_insn [6] = '{32'h123452B7, 32'h00001317, 32'h000000EF,
                              32'h000100E7, 32'h0020A423, 32'hFFF08093};
  logic [31:0] t_pc   [6] = '{32'h80, 32'h100, 32'h200, 32'h204, 32'h208, 32'h20C};
  logic [31:0] t_r1   [6] = '{32'h0, 32'h100, 32'h200, 32'h204, 32'h300, 32'h300};
  logic [31:0] t_r2   [6] = '{32'h12345000, 32'h1000, 32'h4, 32'h4, 32'h8, 32'hFFFFFFFF};

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.id_valid_i = 1'b0;
    bus.id_insn_i = '0;
    bus.id_pc_i = '0;
    bus.id_rs1_data_i = '0;
    bus.id_rs2_data_i = '0;
    bus.ex_ready_i = 1'b1;
    wb_set(1'b0, 5'd0, 32'h0);
    step();
    step();
    chk("rst_ready_low", {31'b0, bus.id_ready_o}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'b0, bus.id_ready_o}, 32'h1);
    chk("rel_valid", {31'b0, bus.ex_valid_o}, 32'h0);

    // ADDI x1,x0,5
    push_set(32'h00500093, 32'h0, 32'h0, 32'h0);
    step();
    bus.id_valid_i = 1'b0;
    #1;
    chk("t1_valid", {31'b0, bus.ex_valid_o}, 32'h1);
    chk("t1_rdata1", bus.ex_rdata1_o, 32'h0);
    chk("t1_rdata2", bus.ex_rdata2_o, 32'h5);
    step();

    // three back-to-back pushes against a stalled EX
    bus.ex_ready_i = 1'b0;
    push_set(32'h00100113, 32'h10, 32'h0, 32'h0);
    step();
    push_set(32'h00200193, 32'h14, 32'h0, 32'h0);
    step();
    push_set(32'h00300213, 32'h18, 32'h0, 32'h0);
    #1;
    chk("t2_full_ready", {31'b0, bus.id_ready_o}, 32'h0);
    step();
    bus.id_valid_i = 1'b0;
    bus.ex_ready_i = 1'b1;
    #1;
    chk("t2_first", bus.ex_insn_o, 32'h00100113);
    step();
    chk("t2_second", bus.ex_insn_o, 32'h00200193);
    step();
    chk("t2_drained", {31'b0, bus.ex_valid_o}, 32'h0);

    // ADD x3,x1,x2 captured with a same-cycle WB to x1
    bus.ex_ready_i = 1'b0;
    push_set(32'h002081B3, 32'h40, 32'h10, 32'h20);
    wb_set(1'b1, 5'd1, 32'h99);
    step();
    bus.id_valid_i = 1'b0;
    wb_set(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_rdata1", bus.ex_rdata1_o, 32'h99);
    chk("t3_rdata2", bus.ex_rdata2_o, 32'h20);

    // held entry picks up later WB; x0 write ignored; head bypass
    wb_set(1'b1, 5'd2, 32'hABCD);
    step();
    wb_set(1'b0, 5'd0, 32'h0);
    #1;
    chk("t4_held_fwd", bus.ex_rdata2_o, 32'hABCD);
    wb_set(1'b1, 5'd0, 32'hDEAD);
    step();
    wb_set(1'b0, 5'd0, 32'h0);
    #1;
    chk("t4_x0_rdata2", bus.ex_rdata2_o, 32'hABCD);
    chk("t4_x0_rdata1", bus.ex_rdata1_o, 32'h99);
    wb_set(1'b1, 5'd1, 32'h55);
    #1;
    chk("t4_bypass", bus.ex_rdata1_o, 32'h55);
    wb_set(1'b0, 5'd0, 32'h0);
    bus.ex_ready_i = 1'b1;
    step();

    // operand-select table: LUI, AUIPC, JAL, JALR, SW, ADDI negative
    for (int i = 0; i < 6; i++) begin
      push_set(t_insn[i], t_pc[i], 32'h300, 32'h444);
      step();
      bus.id_valid_i = 1'b0;
      #1;
      chk("tbl_rdata1", bus.ex_rdata1_o, t_r1[i]);
      chk("tbl_rdata2", bus.ex_rdata2_o, t_r2[i]);
      chk("tbl_rs2",    bus.ex_rs2_data_o, 32'h444);
      step();
    end

    // flush with full buffer and a concurrent push
    bus.ex_ready_i = 1'b0;
    push_set(32'h00100113, 32'h50, 32'h1, 32'h2);
    step();
    push_set(32'h00200193, 32'h54, 32'h3, 32'h4);
    step();
    push_set(32'h00300213, 32'h58, 32'h5, 32'h6);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.id_valid_i = 1'b0;
    #1;
    chk("t6_valid", {31'b0, bus.ex_valid_o}, 32'h0);
    chk("t6_ready", {31'b0, bus.id_ready_o}, 32'h1);
    step();
    chk("t6_stays_empty", {31'b0, bus.ex_valid_o}, 32'h0);

    // reset mid-transfer drops held and incoming
    push_set(32'h00100113, 32'h60, 32'h0, 32'h0);
    step();
    push_set(32'h00200193, 32'h64, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    chk("t7_rst_ready", {31'b0, bus.id_ready_o}, 32'h0);
    step();
    rst = 1'b0;
    bus.id_valid_i = 1'b0;
    #1;
    chk("t7_valid", {31'b0, bus.ex_valid_o}, 32'h0);
    chk("t7_insn", bus.ex_insn_o, 32'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
